// File: rtl/stopwatch_button_ctrl_if.sv
// Button and control bundle of the stopwatch front panel.
// The master drives the raw active-low buttons; the slave returns pulses, levels and FSM state.
interface stopwatch_button_ctrl_if;
  logic       start_stop_n;
  logic       hold_n;
  logic       clear_n;
  logic       start_stop_pulse;
  logic       hold_pulse;
  logic       clear_pulse;
  logic       run;
  logic       freeze;
  logic [1:0] state;

  modport master (
    output start_stop_n,
    output hold_n,
    output clear_n,
    input  start_stop_pulse,
    input  hold_pulse,
    input  clear_pulse,
    input  run,
    input  freeze,
    input  state
  );

  modport slave (
    input  start_stop_n,
    input  hold_n,
    input  clear_n,
    output start_stop_pulse,
    output hold_pulse,
    output clear_pulse,
    output run,
    output freeze,
    output state
  );
endinterface

// File: rtl/stopwatch_button_ctrl.sv
// Stopwatch front panel: synchronizes and debounces three active-low buttons.
// It turns presses into one-cycle pulses and runs the IDLE/RUNNING/PAUSED control FSM.
module stopwatch_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input logic                    CLK_50MHz,
  input logic                    reset,
  stopwatch_button_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_RUNNING = 2'b01;
  localparam logic [1:0] ST_PAUSED  = 2'b10;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel order: bit 0 start_stop, bit 1 hold, bit 2 clear.
  logic [2:0]       raw;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       stable;
  logic [2:0]       press;
  logic [CNT_W-1:0] cnt [3];

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       freeze_q;
  logic       freeze_d;

  assign raw = {bus.clear_n, bus.hold_n, bus.start_stop_n};

  always_ff @(posedge CLK_50MHz or posedge reset) begin
    if (reset) begin
      sync1 <= 3'b111;
      sync2 <= 3'b111;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // A new level is accepted on the DEBOUNCE_CYCLES-th consecutive mismatching
  // sample; the press pulse is registered on that same edge, only for 1->0.
  always_ff @(posedge CLK_50MHz or posedge reset) begin
    if (reset) begin
      stable <= 3'b111;
      press  <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
          press[i]  <= ~sync2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Clear dominates; hold and start_stop may act together, with hold
  // judged against the state before the start_stop transition.
  always_comb begin
    state_d  = state_q;
    freeze_d = freeze_q;
    if (state_q == 2'b11) begin
      state_d  = ST_IDLE;
      freeze_d = 1'b0;
    end else if (press[2]) begin
      state_d  = ST_IDLE;
      freeze_d = 1'b0;
    end else begin
      if (press[1] && (state_q != ST_IDLE)) begin
        freeze_d = ~freeze_q;
      end
      if (press[0]) begin
        case (state_q)
          ST_IDLE:    state_d = ST_RUNNING;
          ST_RUNNING: state_d = ST_PAUSED;
          ST_PAUSED:  state_d = ST_RUNNING;
          default:    state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK_50MHz or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      freeze_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      freeze_q <= freeze_d;
    end
  end

  assign bus.start_stop_pulse = press[0];
  assign bus.hold_pulse       = press[1];
  assign bus.clear_pulse      = press[2];
  assign bus.run              = (state_q == ST_RUNNING);
  assign bus.freeze           = freeze_q;
  assign bus.state            = state_q;

endmodule
